// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton event stage: FSM state type and the
// default timing used by every button instance.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } btn_state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 32'd50000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd10000000;
  localparam int unsigned DEF_CNT_W         = 32'd26;

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat
// event pulses plus a registered held level. All outputs come straight from flops.
module button_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // The press edge itself counts as the first held cycle, hence the -2.
  localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_CYCLES - 32'd2);
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_CYCLES - 32'd1);

  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             press_q;
  logic             release_q;
  logic             click_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;

  assign cnt_inc_d = cnt_q + CNT_W'(1);

  // Event FSM with hold counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pb_debounced) begin
            state_q <= SHORT;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end
        end
        SHORT: begin
          // Release is checked first so it beats a coincident long threshold.
          if (!pb_debounced) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            click_q   <= 1'b1;
            held_q    <= 1'b0;
          end else if (cnt_q == LONG_TH) begin
            state_q <= LONG;
            cnt_q   <= '0;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            state_q <= SHORT;
            cnt_q   <= cnt_inc_d;
            held_q  <= 1'b1;
          end
        end
        LONG: begin
          if (!pb_debounced) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (!repeat_en) begin
            state_q <= LONG;
            cnt_q   <= '0;
            held_q  <= 1'b1;
          end else if (cnt_q == REPEAT_TH) begin
            state_q  <= LONG;
            cnt_q    <= '0;
            repeat_q <= 1'b1;
            held_q   <= 1'b1;
          end else begin
            state_q <= LONG;
            cnt_q   <= cnt_inc_d;
            held_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
